// File: rtl/first_mux_pkg.sv
// Shared defaults and lane-slicing helper for the first_mux21 selector chain.
package first_mux_pkg;

   localparam int DEF_WIDTH  = 1;
   localparam int DEF_STAGES = 2;

   // LSB position of lane k in a bus of WIDTH-wide lanes
   function automatic int lane_lsb(input int k, input int width);
      return k * width;
   endfunction

endpackage

// File: rtl/first_mux_stage.sv
// One WIDTH-wide 2:1 select (sel ? b : a), optionally registered.
module first_mux_stage #(
   parameter int WIDTH = 1,
   parameter int REG   = 0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] y_o
);

   logic [WIDTH-1:0] y_d;

   // Ternary keeps X/Z on the unselected leg from leaking through
   always_comb begin
      y_d = sel_i ? b_i : a_i;
   end

   if (REG != 0) begin : g_reg
      logic [WIDTH-1:0] y_q;
      always_ff @(posedge clk_i) begin
         if (rst_i) y_q <= '0;
         else       y_q <= y_d;
      end
      assign y_o = y_q;
   end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign y_o = y_d;
   end

endmodule

// File: rtl/first_mux21.sv
// Cascaded registered 2:1 selector chain; highest-index set sel wins, none set -> a.
// Optional per-stage result port tap enabled by defining FIRST_MUX_TAP_EN.
module first_mux21
   import first_mux_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter int PIPE   = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic [WIDTH-1:0]         a,
   input  logic [STAGES*WIDTH-1:0]  b,
   input  logic [STAGES-1:0]        sel,
   output logic                     valid_out,
   output logic [WIDTH-1:0]         out
`ifdef FIRST_MUX_TAP_EN
   ,
   output logic [STAGES*WIDTH-1:0]  tap
`endif
);

   localparam int LAT = (PIPE != 0) ? STAGES : 1;
   localparam int TOP = lane_lsb(STAGES - 1, WIDTH);

   logic [STAGES*WIDTH-1:0] s_all;
   logic [LAT-1:0]          vld_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] prev_k;
      logic [WIDTH-1:0] b_k;
      logic             sel_k;

      if (k == 0) begin : g_first
         assign prev_k = a;
      end else begin : g_chain
         assign prev_k = s_all[lane_lsb(k - 1, WIDTH) +: WIDTH];
      end

      // In pipelined mode stage k sees its override k cycles late, so every
      // output word is built from a single input sample.
      if (PIPE != 0 && k > 0) begin : g_dly
         logic [WIDTH:0] dly_q [k];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < k; i++) dly_q[i] <= '0;
            end else begin
               dly_q[0] <= {sel[k], b[lane_lsb(k, WIDTH) +: WIDTH]};
               for (int i = 1; i < k; i++) dly_q[i] <= dly_q[i-1];
            end
         end
         assign {sel_k, b_k} = dly_q[k-1];
      end else begin : g_nodly
         assign sel_k = sel[k];
         assign b_k   = b[lane_lsb(k, WIDTH) +: WIDTH];
      end

      first_mux_stage #(
         .WIDTH (WIDTH),
         .REG   ((PIPE != 0) ? 1 : 0)
      ) u_stage (
         .clk_i (clk),
         .rst_i (rst),
         .a_i   (prev_k),
         .b_i   (b_k),
         .sel_i (sel_k),
         .y_o   (s_all[lane_lsb(k, WIDTH) +: WIDTH])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= valid_in;
         for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
      end
   end
   assign valid_out = vld_q[LAT-1];

   if (PIPE != 0) begin : g_out_pipe
      assign out = s_all[TOP +: WIDTH];
   end else begin : g_out_reg
      logic [WIDTH-1:0] out_q;
      always_ff @(posedge clk) begin
         if (rst) out_q <= '0;
         else     out_q <= s_all[TOP +: WIDTH];
      end
      assign out = out_q;
   end

`ifdef FIRST_MUX_TAP_EN
   // Earlier stages finish sooner when pipelined; pad them so tap lines up with out
   for (genvar k = 0; k < STAGES; k++) begin : g_tap
      localparam int DEPTH = (PIPE != 0) ? (STAGES - 1 - k) : 1;
      if (DEPTH == 0) begin : g_direct
         assign tap[lane_lsb(k, WIDTH) +: WIDTH] = s_all[lane_lsb(k, WIDTH) +: WIDTH];
      end else begin : g_align
         logic [WIDTH-1:0] t_q [DEPTH];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < DEPTH; i++) t_q[i] <= '0;
            end else begin
               t_q[0] <= s_all[lane_lsb(k, WIDTH) +: WIDTH];
               for (int i = 1; i < DEPTH; i++) t_q[i] <= t_q[i-1];
            end
         end
         assign tap[lane_lsb(k, WIDTH) +: WIDTH] = t_q[DEPTH-1];
      end
   end
`endif

endmodule

// File: tb/tb_first_mux21.sv
// Bench for first_mux21: four configurations against a sample-history reference model.
module tb_first_mux21;

   typedef struct packed {
      logic        rst;
      logic        vin;
      logic [7:0]  a;
      logic [23:0] b;
      logic [2:0]  sel;
   } hist_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        vin;
   logic [7:0]  a_v;
   logic [23:0] b_v;
   logic [2:0]  sel_v;

   int checks = 0;
   int errors = 0;
   hist_t hist[$];

   logic       d0_out, d0_vout;
   logic       d1_out, d1_vout;
   logic [7:0] d2_out, d3_out;
   logic       d2_vout, d3_vout;
`ifdef FIRST_MUX_TAP_EN
   logic [1:0]  d0_tap, d1_tap;
   logic [23:0] d2_tap;
   logic [15:0] d3_tap;
`endif

   always #5 clk = ~clk;

   first_mux21 #(.WIDTH(1), .STAGES(2), .PIPE(0)) u_d0 (
      .clk(clk), .rst(rst), .valid_in(vin), .a(a_v[0:0]), .b(b_v[1:0]), .sel(sel_v[1:0]),
      .valid_out(d0_vout), .out(d0_out)
`ifdef FIRST_MUX_TAP_EN
      , .tap(d0_tap)
`endif
   );

   first_mux21 #(.WIDTH(1), .STAGES(2), .PIPE(1)) u_d1 (
      .clk(clk), .rst(rst), .valid_in(vin), .a(a_v[0:0]), .b(b_v[1:0]), .sel(sel_v[1:0]),
      .valid_out(d1_vout), .out(d1_out)
`ifdef FIRST_MUX_TAP_EN
      , .tap(d1_tap)
`endif
   );

   first_mux21 #(.WIDTH(8), .STAGES(3), .PIPE(1)) u_d2 (
      .clk(clk), .rst(rst), .valid_in(vin), .a(a_v), .b(b_v), .sel(sel_v),
      .valid_out(d2_vout), .out(d2_out)
`ifdef FIRST_MUX_TAP_EN
      , .tap(d2_tap)
`endif
   );

   first_mux21 #(.WIDTH(8), .STAGES(2), .PIPE(0)) u_d3 (
      .clk(clk), .rst(rst), .valid_in(vin), .a(a_v), .b(b_v[15:0]), .sel(sel_v[1:0]),
      .valid_out(d3_vout), .out(d3_out)
`ifdef FIRST_MUX_TAP_EN
      , .tap(d3_tap)
`endif
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result after stages 0..upto: highest set select wins, otherwise a
   function automatic logic [7:0] ref_stage(input hist_t h, input int w, input int upto);
      logic [7:0] m;
      m = (w == 8) ? 8'hFF : 8'h01;
      for (int k = upto; k >= 0; k--)
         if (h.sel[k]) return 8'(h.b >> (k * w)) & m;
      return h.a & m;
   endfunction

   task automatic check_dut(input string nm, input int w, input int s, input int lat,
                            input logic [7:0] out_a, input logic vout_a,
                            input logic [23:0] tap_a, input bit has_tap);
      int n;
      int idx;
      bit flush;
      logic [7:0]  eo;
      logic        ev;
      logic [23:0] et;
      hist_t h;
      n = hist.size() - 1;
      idx = n - lat + 1;
      flush = (idx < 0);
      if (!flush)
         for (int j = idx; j <= n; j++) if (hist[j].rst) flush = 1'b1;
      eo = '0; ev = 1'b0; et = '0;
      if (!flush) begin
         h = hist[idx];
         eo = ref_stage(h, w, s - 1);
         ev = h.vin;
         for (int k = 0; k < s; k++) et = et | (24'(ref_stage(h, w, k)) << (k * w));
      end
      chk({nm, ".out"}, 32'(out_a), 32'(eo));
      chk({nm, ".valid_out"}, 32'(vout_a), 32'(ev));
      if (has_tap) chk({nm, ".tap"}, 32'(tap_a), 32'(et));
   endtask

   // Compare process: record the sample taken at each edge, then check every DUT
   initial begin
      forever begin
         @(posedge clk);
         hist.push_back('{rst: rst, vin: vin, a: a_v, b: b_v, sel: sel_v});
         #1;
`ifdef FIRST_MUX_TAP_EN
         check_dut("d0", 1, 2, 1, 8'(d0_out), d0_vout, 24'(d0_tap), 1'b1);
         check_dut("d1", 1, 2, 2, 8'(d1_out), d1_vout, 24'(d1_tap), 1'b1);
         check_dut("d2", 8, 3, 3, d2_out, d2_vout, d2_tap, 1'b1);
         check_dut("d3", 8, 2, 1, d3_out, d3_vout, 24'(d3_tap), 1'b1);
`else
         check_dut("d0", 1, 2, 1, 8'(d0_out), d0_vout, 24'h0, 1'b0);
         check_dut("d1", 1, 2, 2, 8'(d1_out), d1_vout, 24'h0, 1'b0);
         check_dut("d2", 8, 3, 3, d2_out, d2_vout, 24'h0, 1'b0);
         check_dut("d3", 8, 2, 1, d3_out, d3_vout, 24'h0, 1'b0);
`endif
      end
   end

   task automatic step(input logic r, input logic v, input logic [7:0] a,
                       input logic [23:0] b, input logic [2:0] s);
      @(negedge clk);
      rst = r; vin = v; a_v = a; b_v = b; sel_v = s;
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1; vin = 1'b1; a_v = 8'h01; b_v = '0; sel_v = '0;

      // Reset held with valid_in and a asserted
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 8'h01, 24'h0, 3'b000);
         chk("lit_rst_out", 32'(d0_out), 32'h0);
         chk("lit_rst_vout", 32'(d0_vout), 32'h0);
      end

      // Unpipelined selection, one cycle latency
      step(1'b0, 1'b1, 8'h01, 24'h0, 3'b000);
      chk("lit_sel00", 32'(d0_out), 32'h1);
      chk("lit_sel00_v", 32'(d0_vout), 32'h1);
      step(1'b0, 1'b1, 8'h01, 24'h0, 3'b001);
      chk("lit_sel01", 32'(d0_out), 32'h0);
      step(1'b0, 1'b1, 8'h01, 24'h0, 3'b011);
      chk("lit_sel11", 32'(d0_out), 32'h0);
      step(1'b0, 1'b1, 8'h01, 24'h2, 3'b010);
      chk("lit_sel10", 32'(d0_out), 32'h1);

      // Pipelined back-to-back alternating 00/11 -> 1,0,1,0 two cycles later
      for (int i = 0; i < 6; i++) begin
         step(1'b0, (i < 4) ? 1'b1 : 1'b0, 8'h01, 24'h0,
              (i < 4 && (i % 2) == 1) ? 3'b011 : 3'b000);
         if (i >= 1 && i <= 4) begin
            chk("lit_pipe_out", 32'(d1_out), ((i - 1) % 2 == 0) ? 32'h1 : 32'h0);
            chk("lit_pipe_v", 32'(d1_vout), 32'h1);
         end
         if (i == 5) chk("lit_pipe_v_end", 32'(d1_vout), 32'h0);
      end

      // Reset with samples in flight flushes the pipes
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 8'($urandom), 24'($urandom), 3'($urandom));
      step(1'b1, 1'b1, 8'hFF, 24'hFFFFFF, 3'b111);
      chk("lit_flush_v1", 32'(d1_vout), 32'h0);
      chk("lit_flush_v2", 32'(d2_vout), 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 8'h00, 24'h0, 3'b000);
         chk("lit_stale_v1", 32'(d1_vout), 32'h0);
         chk("lit_stale_v2", 32'(d2_vout), 32'h0);
         chk("lit_stale_o2", 32'(d2_out), 32'h0);
      end

      // Byte-wide case with stage 0 override
      step(1'b0, 1'b1, 8'hAA, 24'h00550F, 3'b001);
      chk("lit_w8_out", 32'(d3_out), 32'h0F);
`ifdef FIRST_MUX_TAP_EN
      chk("lit_w8_tap", 32'(d3_tap), 32'h0F0F);
`endif

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0, 1'($urandom),
              8'($urandom), 24'($urandom), 3'($urandom));

      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 8'h00, 24'h0, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
